// File: rtl/hwag_ssram_arbiter_if.sv
// Requester handshake bundle for hwag_ssram_arbiter: level req, one-cycle ack,
// read data held until the requester's next read. One instance per requester.
interface hwag_ssram_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/hwag_ssram_arbiter.sv
// Two-requester sequencer for the hwag ssram register bus (setup/strobe/hold/ack).
// Define HWAG_ARB_RR_EN for round-robin arbitration; default is fixed priority to m0.
module hwag_ssram_arbiter #(
   parameter int AW            = 8,
   parameter int DW            = 16,
   parameter int STROBE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   hwag_ssram_arbiter_if.slave m0,
   hwag_ssram_arbiter_if.slave m1,
   output logic                ssram_we,
   output logic                ssram_re,
   output logic [AW-1:0]       ssram_addr,
   inout  wire  [DW-1:0]       ssram_data,
   output logic                busy,
   output logic                grant
);

   localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   generate
      if (STROBE_CYCLES < 1) begin : g_bad_strobe
         $error("hwag_ssram_arbiter: STROBE_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          lat_we;
   logic [DW-1:0] lat_wdata;
   logic [DW-1:0] rd_sample;
   logic          drive;
   logic          win;

`ifdef HWAG_ARB_RR_EN
   logic last_grant;

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      win = m1.req;
      if (m0.req && m1.req) win = ~last_grant;
   end
`else
   always_comb win = ~m0.req;
`endif

   assign ssram_data = drive ? lat_wdata : 'z;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         rd_sample  <= '0;
         drive      <= 1'b0;
         ssram_we   <= 1'b0;
         ssram_re   <= 1'b0;
         ssram_addr <= '0;
         busy       <= 1'b0;
         grant      <= 1'b0;
         m0.ack     <= 1'b0;
         m1.ack     <= 1'b0;
         m0.rdata   <= '0;
         m1.rdata   <= '0;
`ifdef HWAG_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (m0.req || m1.req) begin
                  grant      <= win;
                  lat_we     <= win ? m1.we    : m0.we;
                  ssram_addr <= win ? m1.addr  : m0.addr;
                  lat_wdata  <= win ? m1.wdata : m0.wdata;
                  drive      <= win ? m1.we    : m0.we;
                  busy       <= 1'b1;
                  state      <= SETUP;
`ifdef HWAG_ARB_RR_EN
                  last_grant <= win;
`endif
               end
            end
            SETUP: begin
               cnt      <= CW'(STROBE_CYCLES - 1);
               ssram_we <= lat_we;
               ssram_re <= ~lat_we;
               state    <= STROBE;
            end
            STROBE: begin
               // Read data is captured on the edge that closes the last strobe cycle.
               if (cnt == '0) begin
                  ssram_we <= 1'b0;
                  ssram_re <= 1'b0;
                  if (!lat_we) rd_sample <= ssram_data;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               drive <= 1'b0;
               if (grant) begin
                  m1.ack <= 1'b1;
                  if (!lat_we) m1.rdata <= rd_sample;
               end else begin
                  m0.ack <= 1'b1;
                  if (!lat_we) m0.rdata <= rd_sample;
               end
               state <= ACK;
            end
            ACK: begin
               m0.ack <= 1'b0;
               m1.ack <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hwag_ssram_arbiter.sv
// Self-checking bench for hwag_ssram_arbiter: a STROBE_CYCLES=1 instance and a
// STROBE_CYCLES=3 instance, each with its own bus model, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_hwag_ssram_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int S  = 1;
   localparam int S3 = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hwag_ssram_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
   hwag_ssram_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
   hwag_ssram_arbiter_if #(.AW(AW), .DW(DW)) l0_if ();
   hwag_ssram_arbiter_if #(.AW(AW), .DW(DW)) l1_if ();

   logic          ssram_we, ssram_re, busy, grant;
   logic [AW-1:0] ssram_addr;
   wire  [DW-1:0] ssram_data;
   logic          tb_en;
   logic [DW-1:0] tb_val;
   assign ssram_data = tb_en ? tb_val : 'z;

   logic          ssram_we3, ssram_re3, busy3, grant3;
   logic [AW-1:0] ssram_addr3;
   wire  [DW-1:0] ssram_data3;
   logic          tb_en3;
   logic [DW-1:0] tb_val3;
   assign ssram_data3 = tb_en3 ? tb_val3 : 'z;

   hwag_ssram_arbiter #(.AW(AW), .DW(DW), .STROBE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
      .ssram_we(ssram_we), .ssram_re(ssram_re), .ssram_addr(ssram_addr),
      .ssram_data(ssram_data), .busy(busy), .grant(grant)
   );

   hwag_ssram_arbiter #(.AW(AW), .DW(DW), .STROBE_CYCLES(S3)) dut3 (
      .clk(clk), .rst(rst), .m0(l0_if), .m1(l1_if),
      .ssram_we(ssram_we3), .ssram_re(ssram_re3), .ssram_addr(ssram_addr3),
      .ssram_data(ssram_data3), .busy(busy3), .grant(grant3)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state: who won the last arbitration, and what each requester's rdata must read.
   bit            model_last;
   logic [DW-1:0] exp_rd [2];

   function automatic bit arb(input bit r0, input bit r1);
      bit w;
`ifdef HWAG_ARB_RR_EN
      if (r0 && r1) w = ~model_last;
      else          w = r1;
`else
      w = ~r0;
`endif
      model_last = w;
      return w;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input bit r, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (m == 0) begin
         m0_if.req = r; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
      end else begin
         m1_if.req = r; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
      end
   endtask

   task automatic test_reset;
      bit w;
      rst = 1'b0;
      set_req(0, 1'b1, 1'b1, 8'h11, 16'h1111);
      set_req(1, 1'b1, 1'b1, 8'h22, 16'h2222);
      l0_if.req = 1'b0; l0_if.we = 1'b0; l0_if.addr = '0; l0_if.wdata = '0;
      l1_if.req = 1'b0; l1_if.we = 1'b0; l1_if.addr = '0; l1_if.wdata = '0;
      tb_en = 1'b1;  tb_val  = 16'hC3C3;
      tb_en3 = 1'b1; tb_val3 = 16'h3C3C;
      model_last = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (3) tick;
      #1;
      total++;
      if ({ssram_we, ssram_re, busy, grant, m0_if.ack, m1_if.ack} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got we/re/busy/grant/ack0/ack1=%b exp 000000",
                  {ssram_we, ssram_re, busy, grant, m0_if.ack, m1_if.ack});
      end
      total++;
      if (ssram_addr !== '0) begin
         bad++; $display("FAIL reset_addr: got %h exp 00", ssram_addr);
      end
      total++;
      if ({m0_if.rdata, m1_if.rdata} !== 32'h0) begin
         bad++; $display("FAIL reset_rdata: got %h/%h exp 0000/0000", m0_if.rdata, m1_if.rdata);
      end
      total++;
      if (ssram_data !== 16'hC3C3) begin
         bad++; $display("FAIL reset_bus_z: got %h exp %h (bench value only)", ssram_data, 16'hC3C3);
      end
      total++;
      if ({ssram_we3, ssram_re3, busy3, grant3, ssram_data3} !== {4'b0, 16'h3C3C}) begin
         bad++;
         $display("FAIL reset_dut3: got %b %h exp 0000 3c3c",
                  {ssram_we3, ssram_re3, busy3, grant3}, ssram_data3);
      end
      tb_en = 1'b0; tb_en3 = 1'b0;
      rst = 1'b1;
      w = arb(1'b1, 1'b1);
      tick; #1;
      total++;
      if ({busy, grant} !== {1'b1, w}) begin
         bad++; $display("FAIL reset_first_grant: got busy/grant=%b%b exp 1%b", busy, grant, w);
      end
      set_req(1, 1'b0, 1'b0, '0, '0);
      for (int c = 2; c <= 3 + S; c++) tick;
      #1;
      total++;
      if ({m0_if.ack, m1_if.ack} !== 2'b10) begin
         bad++; $display("FAIL reset_first_ack: got ack0/ack1=%b%b exp 10", m0_if.ack, m1_if.ack);
      end
      set_req(0, 1'b0, 1'b0, '0, '0);
      tick; #1;
   endtask

   task automatic test_single;
      int            m;
      bit            wr, w, stb, dut_drv;
      logic [AW-1:0] a;
      logic [DW-1:0] d, rv;
      logic [4:0]    exp_ctrl;
      logic [DW-1:0] exp_bus;
      for (int t = 0; t < 10; t++) begin
         m  = (t < 2) ? t : int'($urandom_range(0, 1));
         wr = (t == 0) ? 1'b1 : (t == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         a  = (t == 0) ? 8'h05 : (t == 1) ? 8'h03 : AW'($urandom);
         rv = (t == 1) ? 16'hBEEF : DW'($urandom);
         d  = (t == 0) ? 16'h1234 : (wr ? DW'($urandom) : ~rv);
         set_req(m, 1'b1, wr, a, d);
         w = arb(m == 0, m == 1);
         for (int c = 1; c <= 4 + S; c++) begin
            tick;
            stb     = (c >= 2) && (c <= 1 + S);
            dut_drv = wr && (c <= 2 + S);
            if (dut_drv) tb_en = 1'b0;
            else begin
               tb_en  = 1'b1;
               tb_val = (!wr && stb) ? rv : DW'($urandom);
            end
            exp_bus = dut_drv ? d : tb_val;
            #1;
            exp_ctrl = {wr && stb, !wr && stb, c <= 3 + S, c == 3 + S && m == 0, c == 3 + S && m == 1};
            total++;
            if ({ssram_we, ssram_re, busy, m0_if.ack, m1_if.ack} !== exp_ctrl) begin
               bad++;
               $display("FAIL single_ctrl t%0d c%0d: got we/re/busy/ack0/ack1=%b exp %b",
                        t, c, {ssram_we, ssram_re, busy, m0_if.ack, m1_if.ack}, exp_ctrl);
            end
            total++;
            if (grant !== w) begin
               bad++; $display("FAIL single_grant t%0d c%0d: got %b exp %b", t, c, grant, w);
            end
            if (c <= 2 + S) begin
               total++;
               if (ssram_addr !== a) begin
                  bad++; $display("FAIL single_addr t%0d c%0d: got %h exp %h", t, c, ssram_addr, a);
               end
            end
            total++;
            if (ssram_data !== exp_bus) begin
               bad++; $display("FAIL single_bus t%0d c%0d: got %h exp %h", t, c, ssram_data, exp_bus);
            end
            if (c == 3 + S) begin
               if (!wr) exp_rd[m] = rv;
               total++;
               if ({m0_if.rdata, m1_if.rdata} !== {exp_rd[0], exp_rd[1]}) begin
                  bad++;
                  $display("FAIL single_rdata t%0d: got %h/%h exp %h/%h",
                           t, m0_if.rdata, m1_if.rdata, exp_rd[0], exp_rd[1]);
               end
               set_req(m, 1'b0, 1'b0, '0, '0);
            end
         end
         tb_en = 1'b0;
      end
   endtask

   task automatic test_reset_mid_strobe;
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d, probe;
      logic [4:0]    exp_ctrl;
      a = AW'($urandom); d = DW'($urandom);
      set_req(0, 1'b1, 1'b1, a, d);
      w = arb(1'b1, 1'b0);
      tick; tick; #1;
      total++;
      if (ssram_we !== 1'b1) begin
         bad++; $display("FAIL mid_pre_we: got %b exp 1", ssram_we);
      end
      #1 rst = 1'b0;
      model_last = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      #1;
      total++;
      if ({ssram_we, ssram_re, busy, grant, m0_if.ack, m1_if.ack, ssram_addr} !== '0) begin
         bad++;
         $display("FAIL mid_reset_out: got %b addr %h exp all zero",
                  {ssram_we, ssram_re, busy, grant, m0_if.ack, m1_if.ack}, ssram_addr);
      end
      total++;
      if ({m0_if.rdata, m1_if.rdata} !== 32'h0) begin
         bad++; $display("FAIL mid_reset_rdata: got %h/%h exp 0/0", m0_if.rdata, m1_if.rdata);
      end
      probe = DW'($urandom);
      tb_en = 1'b1; tb_val = probe;
      #1;
      total++;
      if (ssram_data !== probe) begin
         bad++; $display("FAIL mid_reset_bus_z: got %h exp %h", ssram_data, probe);
      end
      tick; tick;
      tb_en = 1'b0;
      #1 rst = 1'b1;
      w = arb(1'b1, 1'b0);
      for (int c = 1; c <= 4 + S; c++) begin
         tick; #1;
         exp_ctrl = {c >= 2 && c <= 1 + S, 1'b0, c <= 3 + S, c == 3 + S, 1'b0};
         total++;
         if ({ssram_we, ssram_re, busy, m0_if.ack, m1_if.ack} !== exp_ctrl) begin
            bad++;
            $display("FAIL mid_retry_ctrl c%0d: got %b exp %b",
                     c, {ssram_we, ssram_re, busy, m0_if.ack, m1_if.ack}, exp_ctrl);
         end
         if (c == 1) begin
            total++;
            if ({grant, ssram_addr, ssram_data} !== {w, a, d}) begin
               bad++;
               $display("FAIL mid_retry_setup: got %b %h %h exp %b %h %h",
                        grant, ssram_addr, ssram_data, w, a, d);
            end
         end
         if (c == 3 + S) set_req(0, 1'b0, 1'b0, '0, '0);
      end
   endtask

   task automatic test_arbitration;
      logic [AW-1:0] a [2][2];
      logic [DW-1:0] d [2][2];
      int            idx [2];
      int            n [2];
      bit            order [4];
      int            k, p, who;
      logic [4:0]    exp_ctrl;
      rst = 1'b0;
      #1 rst = 1'b1;
      model_last = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            a[i][j] = AW'($urandom); d[i][j] = DW'($urandom);
         end
      n[0] = 2; n[1] = 2; idx[0] = 0; idx[1] = 0;
      for (int i = 0; i < 4; i++) begin
         order[i] = arb(n[0] > 0, n[1] > 0);
         n[order[i]]--;
      end
      set_req(0, 1'b1, 1'b1, a[0][0], d[0][0]);
      set_req(1, 1'b1, 1'b1, a[1][0], d[1][0]);
      for (int c = 1; c <= 4 * (4 + S); c++) begin
         tick; #1;
         k   = (c - 1) / (4 + S);
         p   = (c - 1) % (4 + S) + 1;
         who = int'(order[k]);
         exp_ctrl = {p >= 2 && p <= 1 + S, 1'b0, p <= 3 + S, p == 3 + S && who == 0, p == 3 + S && who == 1};
         total++;
         if ({ssram_we, ssram_re, busy, m0_if.ack, m1_if.ack} !== exp_ctrl) begin
            bad++;
            $display("FAIL arb_ctrl txn%0d phase%0d: got %b exp %b",
                     k, p, {ssram_we, ssram_re, busy, m0_if.ack, m1_if.ack}, exp_ctrl);
         end
         if (p == 1) begin
            total++;
            if ({grant, ssram_addr, ssram_data} !== {order[k], a[who][idx[who]], d[who][idx[who]]}) begin
               bad++;
               $display("FAIL arb_grant txn%0d: got %b %h %h exp %b %h %h", k, grant, ssram_addr,
                        ssram_data, order[k], a[who][idx[who]], d[who][idx[who]]);
            end
         end
         if (p == 3 + S) begin
            idx[who]++;
            if (idx[who] < 2) set_req(who, 1'b1, 1'b1, a[who][idx[who]], d[who][idx[who]]);
            else              set_req(who, 1'b0, 1'b0, '0, '0);
         end
      end
   endtask

   task automatic test_long_strobe;
      bit            wr, stb, dut_drv;
      logic [AW-1:0] a;
      logic [DW-1:0] d, rv;
      logic [3:0]    exp_ctrl;
      logic [DW-1:0] exp_bus;
      for (int t = 0; t < 2; t++) begin
         wr = (t == 0);
         a  = AW'($urandom); rv = DW'($urandom);
         d  = wr ? DW'($urandom) : ~rv;
         l0_if.req = 1'b1; l0_if.we = wr; l0_if.addr = a; l0_if.wdata = d;
         for (int c = 1; c <= 4 + S3; c++) begin
            tick;
            stb     = (c >= 2) && (c <= 1 + S3);
            dut_drv = wr && (c <= 2 + S3);
            if (dut_drv) tb_en3 = 1'b0;
            else begin
               // Only the final strobe cycle carries the value that must be captured.
               tb_en3  = 1'b1;
               tb_val3 = (!wr && c == 1 + S3) ? rv : DW'($urandom);
            end
            exp_bus = dut_drv ? d : tb_val3;
            #1;
            exp_ctrl = {wr && stb, !wr && stb, c <= 3 + S3, c == 3 + S3};
            total++;
            if ({ssram_we3, ssram_re3, busy3, l0_if.ack} !== exp_ctrl) begin
               bad++;
               $display("FAIL long_ctrl t%0d c%0d: got we/re/busy/ack=%b exp %b",
                        t, c, {ssram_we3, ssram_re3, busy3, l0_if.ack}, exp_ctrl);
            end
            total++;
            if (ssram_data3 !== exp_bus) begin
               bad++; $display("FAIL long_bus t%0d c%0d: got %h exp %h", t, c, ssram_data3, exp_bus);
            end
            if (c == 3 + S3) begin
               if (!wr) begin
                  total++;
                  if (l0_if.rdata !== rv) begin
                     bad++; $display("FAIL long_rdata: got %h exp %h", l0_if.rdata, rv);
                  end
               end
               l0_if.req = 1'b0;
            end
         end
         tb_en3 = 1'b0;
      end
   endtask

   initial begin
      tb_en  = 1'b0; tb_val  = '0;
      tb_en3 = 1'b0; tb_val3 = '0;
      test_reset;
      test_single;
      test_reset_mid_strobe;
      test_arbitration;
      test_long_strobe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hwag_ssram_arbiter.md
Name: hwag_ssram_arbiter

Overview:
- Sequences the hwag ssram register bus: ssram_we, ssram_re, 8-bit ssram_addr, 16-bit bidirectional ssram_data.
- Shares that bus between two requesters (m0: host bridge, m1: internal config loader) using a req/ack handshake.
- Generates setup, strobe and hold phases, owns the tristate data driver, and returns read data to the requester.

Parameters:
- AW, 8: address width.
- DW, 16: data width.
- STROBE_CYCLES, 1: cycles ssram_we/ssram_re stay high. Must be >= 1; elaboration error if 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 transaction request, level; hold until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  m0 address.
- m0_wdata  in  DW  m0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  m0 read data, valid with m0_ack, held until m0's next read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for m1.
- ssram_we  out  1  write strobe.
- ssram_re  out  1  read strobe.
- ssram_addr  out  AW  bus address.
- ssram_data  inout  DW  bus data; driven only during write phases, else high-Z.
- busy  out  1  high in every non-IDLE state.
- grant  out  1  owner of the current transaction (0 = m0, 1 = m1); holds its last value when idle.

Behaviour:
- States: IDLE, SETUP, STROBE, HOLD, ACK.
- IDLE:
  - If any req is high, arbitrate.
  - Latch the winner's we, addr and wdata into internal registers; set grant; go to SETUP.
  - If no req is high, stay in IDLE.
- SETUP (1 cycle):
  - ssram_addr = latched addr.
  - On a write, ssram_data is driven with latched wdata.
  - ssram_we = ssram_re = 0.
- STROBE (STROBE_CYCLES cycles):
  - ssram_we (write) or ssram_re (read) is high; a down-counter sets the duration.
  - Read: ssram_data is sampled at the clock edge that ends the last STROBE cycle.
- HOLD (1 cycle): strobes low; addr and write data still driven.
- ACK (1 cycle):
  - Granted mX_ack = 1. On a read, mX_rdata is updated with the sampled value.
  - ssram_data released; next state IDLE.
- Latency: if req is sampled in IDLE cycle 0, ack is high in cycle 3+STROBE_CYCLES.
  - Bus occupancy is 4+STROBE_CYCLES cycles per transaction, including the IDLE cycle.
- Back-to-back: a requester may keep req high after ack to present a new transaction. It is re-sampled in the IDLE cycle that follows ACK.
- Requester inputs are latched in IDLE; later changes do not affect the transaction in flight.
- Arbitration without the macro: fixed priority, m0 wins when both request.
- Tristate: ssram_data is high-Z in IDLE and ACK, and throughout read transactions. The block never drives the bus on a read.
- Strobe exclusivity: ssram_we and ssram_re are never high together, and are never high outside STROBE.
- Reset (rst low, at any time including mid-transaction):
  - State goes to IDLE and the transaction is aborted with no ack.
  - Outputs: ssram_we = ssram_re = 0, ssram_addr = 0, ssram_data high-Z.
  - m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, busy = 0, grant = 0.
  - After reset release, the requester must still hold req; the transaction is re-arbitrated from scratch.

Optional Feature:
- Macro HWAG_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant register (reset value 1) is updated in each IDLE->SETUP transition.
  - When both requesters are high, grant goes to the requester other than last_grant, so m0 wins the first tie after reset.
- Undefined: fixed priority to m0; no last_grant register.
- Single-requester timing is identical in both builds.

Test Plan:
- Reset: rst=0 with both req high -> all outputs 0, ssram_data Z, busy 0, no ack; release -> m0 is granted first.
- m0 write addr 0x05 data 0x1234, STROBE_CYCLES=1:
  - Cycle 1: ssram_addr=0x05, ssram_data=0x1234, we=0.
  - Cycle 2: we=1.
  - Cycle 3: we=0, data still 0x1234.
  - Cycle 4: m0_ack=1, data Z.
- m1 read addr 0x03, bus model drives 0xBEEF -> ssram_re high exactly 1 cycle; m1_rdata=0xBEEF with m1_ack; block never drives ssram_data; m0_rdata unchanged.
- Both req held high for 2 transactions each:
  - No macro: grant order m0,m0,m1,m1.
  - With HWAG_ARB_RR_EN: m0,m1,m0,m1.
- STROBE_CYCLES=3 write -> we high 3 consecutive cycles, ack in cycle 6, busy high in cycles 1–6.
- rst pulsed low during STROBE of an m0 write -> we drops immediately, no m0_ack, bus Z; after release with req still high, the transaction completes with normal timing.
